// File: rtl/sfp_peer_sum_reader_if.sv
// sfp_peer_sum_reader_if
//   Bundles the peer-FIFO side and the local SFP-row side of the cross-core
//   row-sum reader.
//   master : stimulus / environment side (drives peer_wr, peer_sum, div_req)
//   slave  : sfp_peer_sum_reader (drives peer_rd, div, sum_in, pending,
//            ovf, req_ovf)
//   sum_w  : row-sum word width (bw_psum + 4)
interface sfp_peer_sum_reader_if #(
  parameter int sum_w = 24
) ();
  logic             peer_wr;
  logic [sum_w-1:0] peer_sum;
  logic             peer_rd;
  logic             div_req;
  logic             div;
  logic [sum_w-1:0] sum_in;
  logic [3:0]       pending;
  logic             ovf;
  logic             req_ovf;

  modport master (
    output peer_wr, peer_sum, div_req,
    input  peer_rd, div, sum_in, pending, ovf, req_ovf
  );

  modport slave (
    input  peer_wr, peer_sum, div_req,
    output peer_rd, div, sum_in, pending, ovf, req_ovf
  );
endinterface

// File: rtl/sfp_peer_sum_reader.sv
// sfp_peer_sum_reader
//   Drains the peer core's row-sum FIFO into a small local circular buffer and
//   hands each sum to the local SFP row with a one-cycle div strobe.
//   clk, reset : clock and synchronous active-high reset
//   bus.peer_wr/peer_sum/peer_rd : peer FIFO write strobe, head word, pop strobe
//   bus.div_req/div/sum_in       : local normalize request, divide strobe, sum
//   bus.pending                  : requests accepted but not yet issued
//   bus.ovf/req_ovf              : sticky credit / request overflow flags
module sfp_peer_sum_reader #(
  parameter int bw         = 8,
  parameter int bw_psum    = 2*bw+4,
  parameter int lbuf_depth = 4,
  parameter int peer_depth = 16
) (
  input logic                  clk,
  input logic                  reset,
  sfp_peer_sum_reader_if.slave bus
);
  localparam int sum_w  = bw_psum + 4;
  localparam int ptr_w  = $clog2(lbuf_depth);
  localparam int cnt_w  = $clog2(lbuf_depth + 1);
  localparam int pcnt_w = $clog2(peer_depth + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t           state_r;
  logic             peer_rd_r;
  logic [pcnt_w-1:0] peer_cnt_r;
  logic [sum_w-1:0] lbuf_r [lbuf_depth];
  logic [ptr_w-1:0] wr_ptr_r;
  logic [ptr_w-1:0] rd_ptr_r;
  logic [cnt_w-1:0] lbuf_cnt_r;
  logic [3:0]       pending_r;
  logic             div_r;
  logic [sum_w-1:0] sum_in_r;
  logic             ovf_r;
  logic             req_ovf_r;

  logic              buf_wr_s;
  logic              buf_pop_s;
  logic [ptr_w-1:0]  rd_ptr_nxt_s;
  logic [cnt_w-1:0]  lbuf_cnt_nxt_s;
  logic [sum_w-1:0]  head_nxt_s;
  logic              fetch_ok_s;
  logic [pcnt_w-1:0] peer_cnt_nxt_s;
  logic              ovf_set_s;
  logic              req_drop_s;
  logic              req_acc_s;
  logic [3:0]        pending_nxt_s;
  logic              div_set_s;

  // The buffer is written at the end of the POP cycle (the peer head is
  // already valid) and popped at the end of every div cycle.
  assign buf_wr_s  = peer_rd_r;
  assign buf_pop_s = div_r;

  // Credit counter mirrors the peer FIFO occupancy; a write into a full FIFO
  // is flagged rather than counted.
  always_comb begin
    ovf_set_s      = 1'b0;
    peer_cnt_nxt_s = peer_cnt_r;
    if (bus.peer_wr && !peer_rd_r) begin
      if (peer_cnt_r == pcnt_w'(peer_depth)) begin
        ovf_set_s = 1'b1;
      end else begin
        peer_cnt_nxt_s = peer_cnt_r + pcnt_w'(1);
      end
    end else if (!bus.peer_wr && peer_rd_r) begin
      peer_cnt_nxt_s = peer_cnt_r - pcnt_w'(1);
    end else begin
      peer_cnt_nxt_s = peer_cnt_r;
    end
  end

  // Next buffer occupancy and the word that will sit at the head next cycle.
  // The head bypasses the incoming peer word when it lands in an empty slot so
  // sum_in is ready a cycle before div can rise.
  always_comb begin
    rd_ptr_nxt_s = buf_pop_s ? (rd_ptr_r + ptr_w'(1)) : rd_ptr_r;
    case ({buf_wr_s, buf_pop_s})
      2'b10:   lbuf_cnt_nxt_s = lbuf_cnt_r + cnt_w'(1);
      2'b01:   lbuf_cnt_nxt_s = lbuf_cnt_r - cnt_w'(1);
      default: lbuf_cnt_nxt_s = lbuf_cnt_r;
    endcase
    if (buf_wr_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = bus.peer_sum;
    end else begin
      head_nxt_s = lbuf_r[rd_ptr_nxt_s];
    end
    // A pop this cycle frees a slot in time for the next fetch.
    fetch_ok_s = (peer_cnt_r != pcnt_w'(0)) &&
                 ((lbuf_cnt_r < cnt_w'(lbuf_depth)) || buf_pop_s);
  end

  // Request bookkeeping: a request arriving with the queue full and no issue
  // this cycle is dropped and flagged.
  always_comb begin
    req_drop_s = bus.div_req && (pending_r == 4'd15) && !div_r;
    req_acc_s  = bus.div_req && !req_drop_s;
    case ({req_acc_s, div_r})
      2'b10:   pending_nxt_s = pending_r + 4'd1;
      2'b01:   pending_nxt_s = pending_r - 4'd1;
      default: pending_nxt_s = pending_r;
    endcase
    div_set_s = !div_r && (pending_r != 4'd0) && (lbuf_cnt_r != cnt_w'(0));
  end

  // Local buffer storage; contents are only ever read behind a valid count.
  always_ff @(posedge clk) begin
    if (buf_wr_s) begin
      lbuf_r[wr_ptr_r] <= bus.peer_sum;
    end
  end

  // Fetch FSM plus all control/status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      peer_rd_r  <= 1'b0;
      peer_cnt_r <= '0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      lbuf_cnt_r <= '0;
      pending_r  <= 4'd0;
      div_r      <= 1'b0;
      sum_in_r   <= '0;
      ovf_r      <= 1'b0;
      req_ovf_r  <= 1'b0;
    end else begin
      peer_cnt_r <= peer_cnt_nxt_s;
      ovf_r      <= ovf_r | ovf_set_s;
      req_ovf_r  <= req_ovf_r | req_drop_s;
      pending_r  <= pending_nxt_s;
      div_r      <= div_set_s;
      lbuf_cnt_r <= lbuf_cnt_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      if (buf_wr_s) begin
        wr_ptr_r <= wr_ptr_r + ptr_w'(1);
      end
      // sum_in tracks the head, which cannot change during a div cycle.
      if (lbuf_cnt_nxt_s != cnt_w'(0)) begin
        sum_in_r <= head_nxt_s;
      end
      case (state_r)
        ST_IDLE: begin
          if (fetch_ok_s) begin
            state_r   <= ST_POP;
            peer_rd_r <= 1'b1;
          end
        end
        ST_POP: begin
          state_r   <= ST_GAP;
          peer_rd_r <= 1'b0;
        end
        ST_GAP: begin
          // Lets the peer read pointer settle before the next pop.
          state_r   <= ST_IDLE;
          peer_rd_r <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          peer_rd_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.peer_rd = peer_rd_r;
  assign bus.div     = div_r;
  assign bus.sum_in  = sum_in_r;
  assign bus.pending = pending_r;
  assign bus.ovf     = ovf_r;
  assign bus.req_ovf = req_ovf_r;
endmodule
